load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- Read-side companion to the store path.
- Accepts a load request from the execute stage (effective address plus funct3) and runs a single word-sized AHB read.
- Extracts the addressed byte, halfword or word from the returned data and sign- or zero-extends it.
- Returns a registered result with a one-cycle valid pulse to writeback, and holds the pipeline stalled while the bus access is in flight.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- WAIT_LIMIT, 16, maximum wait cycles the unit tolerates in ADDR or DATA before aborting; 0 disables the timeout.

Ports:
- clk_in  input  1  core clock, rising edge
- rst_in  input  1  asynchronous, active-high reset
- funct3_in  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are treated as LW
- iaddr_in  input  32  effective load address
- mem_rd_req_in  input  1  load request; sampled only in IDLE
- ahb_ready_in  input  1  AHB HREADY
- ahb_rdata_in  input  32  AHB HRDATA
- daddrs_out  output  32  word-aligned bus address {addr[31:2],2'b00}
- ahb_btrans_out  output  2  HTRANS: 00 IDLE, 10 NONSEQ
- rd_req_out  output  1  read strobe; high exactly while ahb_btrans_out is NONSEQ
- lu_data_out  output  32  extended load result
- lu_valid_out  output  1  one-cycle pulse, result valid
- misaligned_out  output  1  one-cycle pulse, misaligned request rejected
- bus_err_out  output  1  one-cycle pulse, WAIT_LIMIT expired
- stall_out  output  1  high whenever state is not IDLE

Behaviour:
- Every output is registered. Reset (async, any state, including mid-transfer) forces state IDLE and all outputs to 0, and clears the wait counter.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - mem_rd_req_in=1 and aligned: latch iaddr_in[1:0], funct3_in and the address, then go to ADDR.
  - Aligned means LB/LBU at any offset, LH/LHU with addr[0]=0, LW with addr[1:0]=00.
  - mem_rd_req_in=1 and misaligned: pulse misaligned_out next cycle, stay in IDLE, no bus activity.
  - No request: stay in IDLE.
- ADDR:
  - ahb_btrans_out=10, rd_req_out=1, daddrs_out valid.
  - ahb_ready_in=1 goes to DATA, with btrans=00 and rd_req_out=0.
  - Otherwise hold all bus outputs stable.
- DATA:
  - daddrs_out is held.
  - ahb_ready_in=1 captures ahb_rdata_in, drives the extracted value on lu_data_out, pulses lu_valid_out next cycle, and returns to IDLE.
- Extraction:
  - Byte lane by offset: 00 [7:0], 01 [15:8], 10 [23:16], 11 [31:24].
  - Halfword by addr[1]: 0 [15:0], 1 [31:16].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- lu_data_out holds its last value until the next valid result; it is cleared only by reset.
- Latency with zero wait states:
  - Request high in cycle N.
  - NONSEQ in cycle N+1.
  - Data phase in cycle N+2.
  - lu_valid_out in cycle N+3.
  - Each ahb_ready_in=0 cycle adds one cycle.
- Wait counter:
  - Resets to 0 on entry to ADDR and on entry to DATA; increments on each ready-low cycle.
  - If WAIT_LIMIT>0 and the count reaches WAIT_LIMIT: pulse bus_err_out, force btrans=00, return to IDLE, and do not assert lu_valid_out.
- Requests while not IDLE are ignored; upstream holds them under stall_out.
- The cycle lu_valid_out, bus_err_out or misaligned_out pulses is an IDLE cycle, and a new request is accepted there (back-to-back loads).
- stall_out=1 in ADDR and DATA; it is 0 in the cycle a result is returned.

Decomposition:
- Shared package rv32_lsu_pkg:
  - funct3 load encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - HTRANS constants (HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10).
  - FSM state encoding.
  - This package is also consumed by store_unit.
- One combinational sub-module, load_align:
  - Inputs: rdata, offset[1:0], funct3.
  - Output: extended 32-bit result.
  - Instantiated once; unit-testable standalone.

Test Plan:
- LB at addr 0x1003, zero wait, rdata 0x80AA_BBCC -> NONSEQ at N+1, daddrs_out=0x1000, lu_data_out=0xFFFF_FF80 with lu_valid_out at N+3.
- LHU at addr 0x2002, ready low 2 cycles in DATA, rdata 0x9ABC_1234 -> lu_data_out=0x0000_9ABC, valid at N+5; LH on the same data -> 0xFFFF_9ABC.
- LW at addr 0x3001 -> misaligned_out pulses one cycle, btrans stays 00, no lu_valid_out; LH at 0x3003 gives the same result.
- LW at 0x4000 with ready stuck low, WAIT_LIMIT=16 -> bus_err_out after 16 wait cycles, state returns to IDLE, stall_out drops, lu_data_out unchanged.
- Back-to-back: a second LBU at 0x5001 presented in the valid cycle of a first LW -> accepted; rdata 0x0000_7F00 yields 0x0000_007F.
- Assert rst_in during DATA -> all outputs 0 immediately; the late ready/rdata is ignored and no valid is produced.

Source files
------------

// File: rtl/rv32_lsu_pkg.sv
// Shared load/store-unit definitions: funct3 encodings, HTRANS codes,
// load FSM encoding and the natural-alignment rule for loads.
package rv32_lsu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } lu_state_e;

   // Bytes go anywhere, halfwords need addr[0]=0, everything else is a word.
   function automatic logic load_is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
      case (funct3)
         F3_LB, F3_LBU: load_is_aligned = 1'b1;
         F3_LH, F3_LHU: load_is_aligned = ~offset[0];
         default:       load_is_aligned = (offset == 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword/word from a bus word and extends it
// according to the load funct3.
module load_align
   import rv32_lsu_pkg::*;
(
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      offset_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (offset_i)
         2'b00:   byte_lane = rdata_i[7:0];
         2'b01:   byte_lane = rdata_i[15:8];
         2'b10:   byte_lane = rdata_i[23:16];
         default: byte_lane = rdata_i[31:24];
      endcase
      half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      case (funct3_i)
         F3_LB:   data_o = {{24{byte_lane[7]}}, byte_lane};
         F3_LBU:  data_o = {24'd0, byte_lane};
         F3_LH:   data_o = {{16{half_lane[15]}}, half_lane};
         F3_LHU:  data_o = {16'd0, half_lane};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Load unit: one word-sized AHB read per load request, with alignment check,
// wait-state timeout and a registered, extended result for writeback.
module load_unit
   import rv32_lsu_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned WAIT_LIMIT = 16
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic [2:0]      funct3_in,
   input  logic [XLEN-1:0] iaddr_in,
   input  logic            mem_rd_req_in,
   input  logic            ahb_ready_in,
   input  logic [XLEN-1:0] ahb_rdata_in,
   output logic [XLEN-1:0] daddrs_out,
   output logic [1:0]      ahb_btrans_out,
   output logic            rd_req_out,
   output logic [XLEN-1:0] lu_data_out,
   output logic            lu_valid_out,
   output logic            misaligned_out,
   output logic            bus_err_out,
   output logic            stall_out
);

   localparam int unsigned WCNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

   lu_state_e         state_q;
   logic [1:0]        offset_q;
   logic [2:0]        funct3_q;
   logic [WCNT_W-1:0] wait_q;
   logic [XLEN-1:0]   align_data;
   logic              wait_expired;

   load_align u_align (
      .rdata_i  (ahb_rdata_in),
      .offset_i (offset_q),
      .funct3_i (funct3_q),
      .data_o   (align_data)
   );

   // True on the ready-low cycle that would bring the count up to the limit.
   assign wait_expired = (WAIT_LIMIT != 0) && ((32'(wait_q) + 32'd1) == WAIT_LIMIT);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q        <= ST_IDLE;
         offset_q       <= 2'b00;
         funct3_q       <= 3'b000;
         wait_q         <= '0;
         daddrs_out     <= '0;
         ahb_btrans_out <= HTRANS_IDLE;
         rd_req_out     <= 1'b0;
         lu_data_out    <= '0;
         lu_valid_out   <= 1'b0;
         misaligned_out <= 1'b0;
         bus_err_out    <= 1'b0;
         stall_out      <= 1'b0;
      end else begin
         lu_valid_out   <= 1'b0;
         misaligned_out <= 1'b0;
         bus_err_out    <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (mem_rd_req_in) begin
                  if (load_is_aligned(funct3_in, iaddr_in[1:0])) begin
                     offset_q       <= iaddr_in[1:0];
                     funct3_q       <= funct3_in;
                     daddrs_out     <= {iaddr_in[XLEN-1:2], 2'b00};
                     ahb_btrans_out <= HTRANS_NONSEQ;
                     rd_req_out     <= 1'b1;
                     stall_out      <= 1'b1;
                     wait_q         <= '0;
                     state_q        <= ST_ADDR;
                  end else begin
                     misaligned_out <= 1'b1;
                  end
               end
            end

            ST_ADDR: begin
               if (ahb_ready_in) begin
                  ahb_btrans_out <= HTRANS_IDLE;
                  rd_req_out     <= 1'b0;
                  wait_q         <= '0;
                  state_q        <= ST_DATA;
               end else if (wait_expired) begin
                  ahb_btrans_out <= HTRANS_IDLE;
                  rd_req_out     <= 1'b0;
                  bus_err_out    <= 1'b1;
                  stall_out      <= 1'b0;
                  wait_q         <= '0;
                  state_q        <= ST_IDLE;
               end else begin
                  wait_q <= wait_q + WCNT_W'(1);
               end
            end

            ST_DATA: begin
               if (ahb_ready_in) begin
                  lu_data_out  <= align_data;
                  lu_valid_out <= 1'b1;
                  stall_out    <= 1'b0;
                  state_q      <= ST_IDLE;
               end else if (wait_expired) begin
                  ahb_btrans_out <= HTRANS_IDLE;
                  bus_err_out    <= 1'b1;
                  stall_out      <= 1'b0;
                  wait_q         <= '0;
                  state_q        <= ST_IDLE;
               end else begin
                  wait_q <= wait_q + WCNT_W'(1);
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed scenarios plus randomized loads
// checked against a transaction-level reference model.
module tb_load_unit;

   localparam int unsigned WL = 16;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [2:0]  funct3_in;
   logic [31:0] iaddr_in;
   logic        mem_rd_req_in;
   logic        ahb_ready_in;
   logic [31:0] ahb_rdata_in;
   logic [31:0] daddrs_out;
   logic [1:0]  ahb_btrans_out;
   logic        rd_req_out;
   logic [31:0] lu_data_out;
   logic        lu_valid_out;
   logic        misaligned_out;
   logic        bus_err_out;
   logic        stall_out;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_data = 32'd0;

   load_unit #(.XLEN(32), .WAIT_LIMIT(WL)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .funct3_in      (funct3_in),
      .iaddr_in       (iaddr_in),
      .mem_rd_req_in  (mem_rd_req_in),
      .ahb_ready_in   (ahb_ready_in),
      .ahb_rdata_in   (ahb_rdata_in),
      .daddrs_out     (daddrs_out),
      .ahb_btrans_out (ahb_btrans_out),
      .rd_req_out     (rd_req_out),
      .lu_data_out    (lu_data_out),
      .lu_valid_out   (lu_valid_out),
      .misaligned_out (misaligned_out),
      .bus_err_out    (bus_err_out),
      .stall_out      (stall_out)
   );

   always #5 clk_in = ~clk_in;

   // Flag vector: {btrans[1:0], rd_req, stall, valid, misaligned, bus_err}
   function automatic logic [6:0] flags();
      return {ahb_btrans_out, rd_req_out, stall_out, lu_valid_out, misaligned_out, bus_err_out};
   endfunction

   // Reference model: access size from the load type, natural alignment.
   function automatic bit ref_aligned(input logic [2:0] f3, input logic [31:0] addr);
      int unsigned size;
      case (f3)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         default:        size = 4;
      endcase
      return (addr % size) == 0;
   endfunction

   // Reference model: pick the addressed field arithmetically and extend it.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rd);
      int unsigned off;
      longint      v;
      off = addr % 4;
      case (f3)
         3'b000: begin v = longint'((rd >> (8 * off)) % 256);  if (v >= 128)   v -= 256;   end
         3'b100: v = longint'((rd >> (8 * off)) % 256);
         3'b001: begin v = longint'((rd >> (16 * (off / 2))) % 65536); if (v >= 32768) v -= 65536; end
         3'b101: v = longint'((rd >> (16 * (off / 2))) % 65536);
         default: v = longint'(rd);
      endcase
      return 32'(v);
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Full load transaction; returns in the cycle lu_valid_out is high.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd,
                          input int wa, input int wd);
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      exp_addr = addr - (addr % 4);
      exp_data = ref_load(f3, addr, rd);
      mem_rd_req_in = 1'b1; funct3_in = f3; iaddr_in = addr; ahb_ready_in = 1'($urandom);
      tick();
      mem_rd_req_in = 1'b0; funct3_in = 3'($urandom); iaddr_in = $urandom;
      checks++;
      if ({flags(), daddrs_out} !== {7'b10_1_1_0_0_0, exp_addr})
         $display("FAIL addr_phase addr=%h got flags=%b daddr=%h want flags=1011000 daddr=%h",
                  addr, flags(), daddrs_out, exp_addr);
      if ({flags(), daddrs_out} !== {7'b10_1_1_0_0_0, exp_addr}) errors++;
      for (int i = 0; i < wa; i++) begin
         ahb_ready_in = 1'b0; ahb_rdata_in = $urandom;
         tick();
         checks++;
         if ({flags(), daddrs_out} !== {7'b10_1_1_0_0_0, exp_addr}) begin
            errors++;
            $display("FAIL addr_wait got flags=%b daddr=%h want 1011000 %h", flags(), daddrs_out, exp_addr);
         end
      end
      ahb_ready_in = 1'b1; ahb_rdata_in = $urandom;
      tick();
      checks++;
      if ({flags(), daddrs_out, lu_data_out} !== {7'b00_0_1_0_0_0, exp_addr, last_data}) begin
         errors++;
         $display("FAIL data_phase got flags=%b daddr=%h data=%h want 0001000 %h %h",
                  flags(), daddrs_out, lu_data_out, exp_addr, last_data);
      end
      for (int i = 0; i < wd; i++) begin
         ahb_ready_in = 1'b0; ahb_rdata_in = $urandom;
         tick();
         checks++;
         if ({flags(), daddrs_out, lu_data_out} !== {7'b00_0_1_0_0_0, exp_addr, last_data}) begin
            errors++;
            $display("FAIL data_wait got flags=%b daddr=%h data=%h want 0001000 %h %h",
                     flags(), daddrs_out, lu_data_out, exp_addr, last_data);
         end
      end
      ahb_ready_in = 1'b1; ahb_rdata_in = rd;
      tick();
      ahb_ready_in = 1'b0; ahb_rdata_in = $urandom;
      checks++;
      if ({flags(), lu_data_out} !== {7'b00_0_0_1_0_0, exp_data}) begin
         errors++;
         $display("FAIL result f3=%b addr=%h rd=%h got flags=%b data=%h want 0000100 %h",
                  f3, addr, rd, flags(), lu_data_out, exp_data);
      end
      last_data = exp_data;
   endtask

   task automatic do_misaligned(input logic [2:0] f3, input logic [31:0] addr);
      mem_rd_req_in = 1'b1; funct3_in = f3; iaddr_in = addr;
      tick();
      mem_rd_req_in = 1'b0;
      checks++;
      if ({flags(), lu_data_out} !== {7'b00_0_0_0_1_0, last_data}) begin
         errors++;
         $display("FAIL misaligned f3=%b addr=%h got flags=%b data=%h want 0000010 %h",
                  f3, addr, flags(), lu_data_out, last_data);
      end
      tick();
      checks++;
      if (flags() !== 7'b0) begin
         errors++;
         $display("FAIL misaligned_drop got flags=%b want 0000000", flags());
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1; mem_rd_req_in = 1'b1; funct3_in = 3'b010; iaddr_in = 32'h0;
      ahb_ready_in = 1'b1; ahb_rdata_in = 32'hDEAD_BEEF;
      tick(); tick();
      checks++;
      if ({flags(), daddrs_out, lu_data_out} !== 71'd0) begin
         errors++;
         $display("FAIL reset got flags=%b daddr=%h data=%h want all zero", flags(), daddrs_out, lu_data_out);
      end
      mem_rd_req_in = 1'b0;
      rst_in = 1'b0;
      tick();
   endtask

   task automatic test_lb_zero_wait();
      do_load(3'b000, 32'h0000_1003, 32'h80AA_BBCC, 0, 0);
      checks++;
      if (lu_data_out !== 32'hFFFF_FF80) begin
         errors++;
         $display("FAIL lb_value got %h want ffffff80", lu_data_out);
      end
      tick();
   endtask

   task automatic test_lhu_lh_wait();
      do_load(3'b101, 32'h0000_2002, 32'h9ABC_1234, 0, 2);
      checks++;
      if (lu_data_out !== 32'h0000_9ABC) begin
         errors++;
         $display("FAIL lhu_value got %h want 00009abc", lu_data_out);
      end
      tick();
      do_load(3'b001, 32'h0000_2002, 32'h9ABC_1234, 1, 0);
      checks++;
      if (lu_data_out !== 32'hFFFF_9ABC) begin
         errors++;
         $display("FAIL lh_value got %h want ffff9abc", lu_data_out);
      end
      tick();
   endtask

   task automatic test_misaligned();
      do_misaligned(3'b010, 32'h0000_3001);
      do_misaligned(3'b001, 32'h0000_3003);
      do_misaligned(3'b101, 32'h0000_3001);
   endtask

   // Ready stuck low: first in the address phase, then in the data phase.
   task automatic test_timeout();
      for (int phase = 0; phase < 2; phase++) begin
         mem_rd_req_in = 1'b1; funct3_in = 3'b010; iaddr_in = 32'h0000_4000;
         tick();
         mem_rd_req_in = 1'b0;
         if (phase == 1) begin
            ahb_ready_in = 1'b1;
            tick();
         end
         for (int k = 1; k <= int'(WL); k++) begin
            ahb_ready_in = 1'b0;
            tick();
            if (k < int'(WL)) begin
               checks++;
               if (flags() !== (phase == 0 ? 7'b10_1_1_0_0_0 : 7'b00_0_1_0_0_0)) begin
                  errors++;
                  $display("FAIL timeout_wait phase=%0d k=%0d got flags=%b", phase, k, flags());
               end
            end
         end
         checks++;
         if ({flags(), lu_data_out} !== {7'b00_0_0_0_0_1, last_data}) begin
            errors++;
            $display("FAIL timeout_err phase=%0d got flags=%b data=%h want 0000001 %h",
                     phase, flags(), lu_data_out, last_data);
         end
         tick();
         checks++;
         if (flags() !== 7'b0) begin
            errors++;
            $display("FAIL timeout_idle phase=%0d got flags=%b want 0000000", phase, flags());
         end
      end
   endtask

   task automatic test_back_to_back();
      do_load(3'b010, 32'h0000_5000, 32'h1234_5678, 0, 0);
      do_load(3'b100, 32'h0000_5001, 32'h0000_7F00, 1, 0);
      checks++;
      if (lu_data_out !== 32'h0000_007F) begin
         errors++;
         $display("FAIL b2b_value got %h want 0000007f", lu_data_out);
      end
      do_load(3'b000, 32'h0000_5002, 32'h00F0_0000, 0, 1);
      tick();
   endtask

   task automatic test_reset_mid_data();
      mem_rd_req_in = 1'b1; funct3_in = 3'b010; iaddr_in = 32'h0000_6000;
      tick();
      mem_rd_req_in = 1'b0; ahb_ready_in = 1'b1;
      tick();
      ahb_ready_in = 1'b0;
      #2 rst_in = 1'b1;
      #1;
      checks++;
      if ({flags(), daddrs_out, lu_data_out} !== 71'd0) begin
         errors++;
         $display("FAIL reset_async got flags=%b daddr=%h data=%h want all zero",
                  flags(), daddrs_out, lu_data_out);
      end
      last_data = 32'd0;
      ahb_ready_in = 1'b1; ahb_rdata_in = 32'hCAFE_F00D;
      tick();
      rst_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({flags(), lu_data_out} !== {7'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_late_ready got flags=%b data=%h want 0000000 0", flags(), lu_data_out);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      logic [2:0]  f3;
      logic [31:0] addr;
      for (int n = 0; n < 60; n++) begin
         f3   = f3_tab[$urandom_range(7, 0)];
         addr = $urandom;
         if (ref_aligned(f3, addr)) begin
            do_load(f3, addr, $urandom, $urandom_range(3, 0), $urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) tick();
         end else begin
            do_misaligned(f3, addr);
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_lb_zero_wait();
      test_lhu_lh_wait();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid_data();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
